// File: rtl/driver_gen.sv
// driver_gen: burst stimulus generator feeding a DUT port and a delayed monitor port.
// Optional DRIVER_GEN_STALL_EN macro adds an i_stall input that freezes the whole pipeline.
module driver_gen #(
  parameter int WIDTH     = 32,
  parameter int MON_DELAY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_rand_a,
  input  logic [WIDTH-1:0] i_rand_b,
  input  logic [WIDTH-1:0] i_fmanual_a,
  input  logic [WIDTH-1:0] i_fmanual_b,
  input  logic [WIDTH-1:0] i_fbitset_a,
  input  logic [WIDTH-1:0] i_fbitset_b,
  input  logic [WIDTH-1:0] i_fbitclr_a,
  input  logic [WIDTH-1:0] i_fbitclr_b,
`ifdef DRIVER_GEN_STALL_EN
  input  logic             i_stall,
`endif
  output logic [WIDTH-1:0] o_drive_dut_a,
  output logic [WIDTH-1:0] o_drive_dut_b,
  output logic             o_dut_valid,
  output logic [WIDTH-1:0] o_drive_mon_a,
  output logic [WIDTH-1:0] o_drive_mon_b,
  output logic             o_mon_valid,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_n, r_count;
  logic [1:0]       r_mode;
  logic [4:0]       r_dc;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_f_a, r_f_b;
  logic             r_f_valid;
  logic [WIDTH-1:0] r_m_a [MON_DELAY];
  logic [WIDTH-1:0] r_m_b [MON_DELAY];
  logic [MON_DELAY-1:0] r_m_v;
  logic             w_stall;
  logic [31:0]      w_idx;
  logic [CNT_W-1:0] w_nn;
  logic [WIDTH-1:0] w_one, w_msb, w_s_a, w_s_b;
  logic             w_s_valid;
`ifdef DRIVER_GEN_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif
  // Stage S is combinational off n; stage F is the first registered stage.
  assign w_idx     = 32'(r_n) % 32'(WIDTH);
  assign w_nn      = ~r_n;
  assign w_one     = WIDTH'(1);
  assign w_msb     = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_s_valid = r_state == RUN;
  assign w_s_a = r_mode == 2'd0 ? (i_rand_a | i_fbitset_a) :
                 r_mode == 2'd1 ? i_fmanual_a :
                 r_mode == 2'd2 ? (w_one << w_idx) : WIDTH'(r_n);
  assign w_s_b = r_mode == 2'd0 ? (i_rand_b | i_fbitset_b) :
                 r_mode == 2'd1 ? i_fmanual_b :
                 r_mode == 2'd2 ? (w_msb >> w_idx) : WIDTH'(w_nn);
  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_count <= '0;
      r_mode  <= '0;
      r_dc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!w_stall) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_count <= i_count;
          r_mode  <= i_mode;
          r_n     <= '0;
          r_dc    <= '0;
          r_state <= i_count == '0 ? DONE : RUN;
          r_busy  <= i_count != '0;
          r_done  <= i_count == '0;
        end
        RUN: if (r_n == r_count - 1'b1) r_state <= DRAIN;
             else r_n <= r_n + 1'b1;
        DRAIN: if (r_dc == 5'(MON_DELAY)) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else r_dc <= r_dc + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_dut or negedge reset) begin
    if (!reset) begin
      r_f_a     <= '0;
      r_f_b     <= '0;
      r_f_valid <= 1'b0;
      r_m_v     <= '0;
      for (int k = 0; k < MON_DELAY; k++) begin
        r_m_a[k] <= '0;
        r_m_b[k] <= '0;
      end
    end else if (!w_stall) begin
      r_f_valid <= w_s_valid;
      if (w_s_valid) begin
        r_f_a <= r_mode == 2'd0 ? (w_s_a & ~i_fbitclr_a) : w_s_a;
        r_f_b <= r_mode == 2'd0 ? (w_s_b & ~i_fbitclr_b) : w_s_b;
      end
      r_m_v[0] <= r_f_valid;
      if (r_f_valid) begin
        r_m_a[0] <= r_f_a;
        r_m_b[0] <= r_f_b;
      end
      for (int k = 1; k < MON_DELAY; k++) begin
        r_m_v[k] <= r_m_v[k-1];
        if (r_m_v[k-1]) begin
          r_m_a[k] <= r_m_a[k-1];
          r_m_b[k] <= r_m_b[k-1];
        end
      end
    end
  end
  assign o_drive_dut_a = r_f_a;
  assign o_drive_dut_b = r_f_b;
  assign o_dut_valid   = r_f_valid & ~w_stall;
  assign o_drive_mon_a = r_m_a[MON_DELAY-1];
  assign o_drive_mon_b = r_m_b[MON_DELAY-1];
  assign o_mon_valid   = r_m_v[MON_DELAY-1] & ~w_stall;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
endmodule

// File: tb/tb_driver_gen.sv
// tb_driver_gen: directed checks of driver_gen with WIDTH=32, MON_DELAY=4, CNT_W=16.
module tb_driver_gen;
  localparam int W = 32;
  localparam int MD = 4;
  localparam int CW = 16;
  logic clk_dut = 1'b0;
  logic reset = 1'b0;
  logic i_start = 1'b0;
  logic [CW-1:0] i_count = '0;
  logic [1:0] i_mode = '0;
  logic [W-1:0] i_rand_a = '0, i_rand_b = '0, i_fmanual_a = '0, i_fmanual_b = '0;
  logic [W-1:0] i_fbitset_a = '0, i_fbitset_b = '0, i_fbitclr_a = '0, i_fbitclr_b = '0;
`ifdef DRIVER_GEN_STALL_EN
  logic i_stall = 1'b0;
`endif
  logic [W-1:0] o_drive_dut_a, o_drive_dut_b, o_drive_mon_a, o_drive_mon_b;
  logic o_dut_valid, o_mon_valid, o_busy, o_done;
  int errors = 0;
  int checks = 0;

  driver_gen #(.WIDTH(W), .MON_DELAY(MD), .CNT_W(CW)) dut (
    .clk_dut(clk_dut), .reset(reset), .i_start(i_start), .i_count(i_count), .i_mode(i_mode),
    .i_rand_a(i_rand_a), .i_rand_b(i_rand_b), .i_fmanual_a(i_fmanual_a), .i_fmanual_b(i_fmanual_b),
    .i_fbitset_a(i_fbitset_a), .i_fbitset_b(i_fbitset_b),
    .i_fbitclr_a(i_fbitclr_a), .i_fbitclr_b(i_fbitclr_b),
`ifdef DRIVER_GEN_STALL_EN
    .i_stall(i_stall),
`endif
    .o_drive_dut_a(o_drive_dut_a), .o_drive_dut_b(o_drive_dut_b), .o_dut_valid(o_dut_valid),
    .o_drive_mon_a(o_drive_mon_a), .o_drive_mon_b(o_drive_mon_b), .o_mon_valid(o_mon_valid),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk_dut = ~clk_dut;

  task automatic tick();
    @(posedge clk_dut);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_dutv"}, 64'(o_dut_valid), 64'd0);
    chk({tag, "_monv"}, 64'(o_mon_valid), 64'd0);
    chk({tag, "_duta"}, 64'(o_drive_dut_a), 64'd0);
    chk({tag, "_dutb"}, 64'(o_drive_dut_b), 64'd0);
    chk({tag, "_mona"}, 64'(o_drive_mon_a), 64'd0);
  endtask

  task automatic start(input logic [CW-1:0] cnt, input logic [1:0] md);
    i_start = 1'b1;
    i_count = cnt;
    i_mode = md;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int nd, nm, nv;
    int dt [8];
    logic [W-1:0] exp_a [5];
    exp_a[0] = 32'd1; exp_a[1] = 32'd2; exp_a[2] = 32'd4; exp_a[3] = 32'd8; exp_a[4] = 32'd16;
    #2;
    chk_idle_outputs("reset");
    tick();
    reset = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // walking one, count 5: vectors visible on the 2nd..6th edge after start
    start(16'd5, 2'd2);
    chk("w1_busy", 64'(o_busy), 64'd1);
    chk("w1_nov", 64'(o_dut_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w1_v", 64'(o_dut_valid), 64'd1);
      chk("w1_a", 64'(o_drive_dut_a), 64'(exp_a[i]));
      chk("w1_b", 64'(o_drive_dut_b), 64'(32'h8000_0000 >> i));
    end
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_done) nd++;
      if (i == 0) chk("w1_v_off", 64'(o_dut_valid), 64'd0);
    end
    chk("w1_done_cnt", 64'(nd), 64'd1);
    chk("w1_busy_end", 64'(o_busy), 64'd0);

    // random mode: clear beats set, set ORs into rand
    i_rand_a = 32'h0000_000F; i_fbitset_a = 32'hF000_0000; i_fbitclr_a = 32'h0000_0003;
    i_rand_b = 32'h0000_0100; i_fbitset_b = 32'h0000_0001; i_fbitclr_b = 32'h0000_0100;
    start(16'd1, 2'd0);
    tick();
    chk("rnd_v", 64'(o_dut_valid), 64'd1);
    chk("rnd_a", 64'(o_drive_dut_a), 64'hF000_000C);
    chk("rnd_b", 64'(o_drive_dut_b), 64'h0000_0001);
    nd = 0;
    for (int i = 0; i < 20 && nd == 0; i++) begin
      tick();
      if (o_done) nd++;
    end
    chk("rnd_done", 64'(nd), 64'd1);
    tick();

    // sweep, count 3: monitor trails DUT by exactly MD cycles
    start(16'd3, 2'd3);
    nd = 0; nm = 0; nv = 0;
    for (int i = 2; i < 18; i++) begin
      tick();
      if (o_dut_valid) begin
        chk("sw_a", 64'(o_drive_dut_a), 64'(nv));
        chk("sw_b", 64'(o_drive_dut_b), 64'(16'hFFFF - 16'(nv)));
        dt[nv] = i;
        nv++;
      end
      if (o_mon_valid) begin
        chk("sw_mon_a", 64'(o_drive_mon_a), 64'(nm));
        chk("sw_mon_dly", 64'(i - dt[nm]), 64'(MD));
        nm++;
      end
      if (o_done) nd++;
    end
    chk("sw_dut_cnt", 64'(nv), 64'd3);
    chk("sw_mon_cnt", 64'(nm), 64'd3);
    chk("sw_done_cnt", 64'(nd), 64'd1);

    // count 0 goes straight to done with no vectors
    start(16'd0, 2'd3);
    chk("z_done", 64'(o_done), 64'd1);
    chk("z_busy", 64'(o_busy), 64'd0);
    chk("z_dutv", 64'(o_dut_valid), 64'd0);
    tick();
    chk("z_done_off", 64'(o_done), 64'd0);
    chk("z_dutv2", 64'(o_dut_valid), 64'd0);
    chk("z_monv", 64'(o_mon_valid), 64'd0);

    // second start and mode change during a burst are ignored
    start(16'd2, 2'd3);
    nv = 0; nd = 0;
    i_start = 1'b1; i_count = 16'd7; i_mode = 2'd2;
    tick();
    i_start = 1'b0;
    if (o_dut_valid) begin
      chk("ign_a", 64'(o_drive_dut_a), 64'(nv));
      nv++;
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_dut_valid) begin
        chk("ign_a", 64'(o_drive_dut_a), 64'(nv));
        nv++;
      end
      if (o_done) nd++;
    end
    chk("ign_cnt", 64'(nv), 64'd2);
    chk("ign_done", 64'(nd), 64'd1);

    // asynchronous reset mid-run, then a clean 2-vector burst from n=0
    start(16'd10, 2'd3);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    #1;
    reset = 1'b1;
    tick();
    chk("rst_no_done", 64'(o_done), 64'd0);
    start(16'd2, 2'd3);
    nv = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_dut_valid) begin
        chk("rr_a", 64'(o_drive_dut_a), 64'(nv));
        nv++;
      end
      if (o_done) nd++;
    end
    chk("rr_cnt", 64'(nv), 64'd2);
    chk("rr_done", 64'(nd), 64'd1);

`ifdef DRIVER_GEN_STALL_EN
    // stall for 3 cycles after the 2nd vector: sequence stays 0,1,2,3
    start(16'd4, 2'd3);
    nv = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_dut_valid) begin
        chk("st_a", 64'(o_drive_dut_a), 64'(nv));
        nv++;
        if (nv == 2) begin
          i_stall = 1'b1;
          for (int j = 0; j < 3; j++) begin
            tick();
            chk("st_v_off", 64'(o_dut_valid), 64'd0);
            chk("st_hold_a", 64'(o_drive_dut_a), 64'd1);
          end
          i_stall = 1'b0;
        end
      end
      if (o_done) nd++;
    end
    chk("st_cnt", 64'(nv), 64'd4);
    chk("st_done", 64'(nd), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
